// File: rtl/sahrdaya_lfsr.sv
// sahrdaya_lfsr: 16-bit maximal-length Fibonacci LFSR with byte-wise seed
// loading, a 16-bit step counter and a byte-select output mux.
// Taps x^16+x^14+x^13+x^11+1 give a period of 65535; the all-zero state is
// only reachable through a load and is replaced by SEED on the next step.
module sahrdaya_lfsr #(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] state;
  logic [15:0] cnt;
  logic        fb;
  logic [15:0] next_state;

  logic        step_en;
  logic        load_en;
  logic        load_hi;
  logic [1:0]  out_sel;

  // ui_in[7:5] are reserved and intentionally ignored
  logic        unused_ui;

  assign step_en   = ui_in[0];
  assign load_en   = ui_in[1];
  assign load_hi   = ui_in[2];
  assign out_sel   = ui_in[4:3];
  assign unused_ui = &{1'b0, ui_in[7:5]};

  // Feedback and shifted next state
  always_comb begin
    fb         = state[15] ^ state[13] ^ state[12] ^ state[10];
    next_state = {state[14:0], fb};
  end

  // State and counter update: enable gates everything, load beats step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
      cnt   <= 16'h0000;
    end else if (ena) begin
      if (load_en) begin
        if (load_hi) state[15:8] <= uio_in;
        else         state[7:0]  <= uio_in;
        cnt <= 16'h0000;
      end else if (step_en) begin
        if (state == 16'h0000) state <= SEED;
        else                   state <= next_state;
        cnt <= cnt + 16'h0001;
      end
    end
  end

  // Zero-latency byte mux onto the dedicated outputs
  always_comb begin
    uo_out = 8'h00;
    case (out_sel)
      2'b00:   uo_out = state[7:0];
      2'b01:   uo_out = state[15:8];
      2'b10:   uo_out = cnt[7:0];
      default: uo_out = cnt[15:8];
    endcase
  end

  // Bidirectional pins are permanently inputs
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_sahrdaya_lfsr.sv
// Directed bench for sahrdaya_lfsr: reset, stepping, enable gating, loads,
// zero-state guard and one full LFSR period with counter wrap.
module tb_sahrdaya_lfsr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       en = 1'b0, load = 1'b0, bsel = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [2:0] hi = 3'b000;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  assign ui_in = {hi, sel, bsel, load, en};

  sahrdaya_lfsr dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s == 16'h0000) return 16'h0001;
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_state(output logic [15:0] v);
    sel = 2'b00; #1; v[7:0]  = uo_out;
    sel = 2'b01; #1; v[15:8] = uo_out;
    sel = 2'b00;
  endtask

  task automatic read_cnt(output logic [15:0] v);
    sel = 2'b10; #1; v[7:0]  = uo_out;
    sel = 2'b11; #1; v[15:8] = uo_out;
    sel = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] st, ct, model;
    int zeros, mism;

    // initial reset and output defaults
    do_reset();
    #1;
    chk("reset_uo", {8'h00, uo_out}, 16'h0001);
    chk("uio_oe", {8'h00, uio_oe}, 16'h0000);
    chk("uio_out", {8'h00, uio_out}, 16'h0000);

    // stepping from reset; upper control bits set to show they are ignored
    en = 1'b1; hi = 3'b101;
    repeat (10) tick();
    read_state(st); chk("step10", st, 16'h0400);
    tick(); read_state(st); chk("step11", st, 16'h0801);
    sel = 2'b01; #1; chk("step11_hi", {8'h00, uo_out}, 16'h0008);
    sel = 2'b10; #1; chk("cnt11_lo", {8'h00, uo_out}, 16'h000B);
    sel = 2'b00;
    tick(); read_state(st); chk("step12", st, 16'h1002);
    tick(); read_state(st); chk("step13", st, 16'h2005);
    hi = 3'b000;

    // enable low: step and load requests ignored
    ena = 1'b0; load = 1'b1; uio_in = 8'hFF;
    repeat (4) tick();
    read_state(st); chk("ena_state", st, 16'h2005);
    read_cnt(ct);   chk("ena_cnt", ct, 16'h000D);
    ena = 1'b1; load = 1'b0; en = 1'b0;

    // asynchronous reset mid-cycle
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("async_rst_uo", {8'h00, uo_out}, 16'h0001);
    #2 rst = 1'b0;
    repeat (5) tick();
    chk("idle_uo", {8'h00, uo_out}, 16'h0001);

    // byte loads; low-byte load also requests a step which must lose
    load = 1'b1; bsel = 1'b1; uio_in = 8'hAB; tick();
    bsel = 1'b0; uio_in = 8'hCD; en = 1'b1; tick();
    load = 1'b0; en = 1'b0;
    read_state(st); chk("load_state", st, 16'hABCD);
    read_cnt(ct);   chk("load_cnt", ct, 16'h0000);
    en = 1'b1; tick(); en = 1'b0;
    read_state(st); chk("step_after_load", st, lfsr_step(16'hABCD));
    chk("step_after_load_const", st, 16'h579A);
    read_cnt(ct);   chk("step_after_load_cnt", ct, 16'h0001);

    // zero-state guard
    do_reset();
    #1;
    load = 1'b1; bsel = 1'b0; uio_in = 8'h00; tick(); load = 1'b0;
    chk("zero_uo", {8'h00, uo_out}, 16'h0000);
    tick();
    read_state(st); chk("zero_hold", st, 16'h0000);
    en = 1'b1; tick(); en = 1'b0;
    read_state(st); chk("zero_guard", st, 16'h0001);
    read_cnt(ct);   chk("zero_guard_cnt", ct, 16'h0001);

    // full period from reset
    do_reset();
    #1;
    model = 16'h0001; zeros = 0; mism = 0;
    en = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tick();
      read_state(st);
      model = lfsr_step(model);
      if (st == 16'h0000) zeros++;
      if (st !== model) mism++;
    end
    en = 1'b0;
    chk("period_zeros", zeros[15:0], 16'h0000);
    chk("period_model", mism[15:0], 16'h0000);
    read_state(st); chk("period_state", st, 16'h0001);
    read_cnt(ct);   chk("period_cnt", ct, 16'hFFFF);
    en = 1'b1; tick(); en = 1'b0;
    read_state(st); chk("wrap_state", st, 16'h0002);
    read_cnt(ct);   chk("wrap_cnt", ct, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
